// File: rtl/rv32i_types.sv
// Shared RV32 pipeline types: M-extension op encoding and EX forwarding select.
package rv32i_types;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    FWD_NONE   = 2'b00,
    FWD_EX_MEM = 2'b01,
    FWD_MEM_WB = 2'b10
  } data_forward_t;

  function automatic logic is_div_op(muldiv_op_t op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Final sign correction and result select for the iterative mul/div engine.
module muldiv_sign_fix
  import rv32i_types::*;
#(
  parameter int XLEN = 32
) (
  input  muldiv_op_t        op,
  input  logic              neg_prod,
  input  logic              neg_quo,
  input  logic              neg_rem,
  input  logic              div_zero,
  input  logic              overflow,
  input  logic [2*XLEN-1:0] product,
  input  logic [XLEN-1:0]   quotient,
  input  logic [XLEN-1:0]   remainder,
  output logic [XLEN-1:0]   result
);

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;

  assign prod_fix = neg_prod ? (~product + 1'b1) : product;
  assign quo_fix  = neg_quo ? (~quotient + 1'b1) : quotient;
  assign rem_fix  = neg_rem ? (~remainder + 1'b1) : remainder;

  // Divide-by-zero remainder arrives as the dividend magnitude, so the
  // normal remainder sign fix reproduces rs1 without a special case here.
  always_comb begin
    result = '0;
    case (op)
      OP_MUL:                      result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU: begin
        if (div_zero)      result = '1;
        else if (overflow) result = {1'b1, {(XLEN-1){1'b0}}};
        else               result = quo_fix;
      end
      OP_REM, OP_REMU: begin
        if (overflow) result = '0;
        else          result = rem_fix;
      end
      default:                     result = '0;
    endcase
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide engine in EX; stalls the front end while
// iterating and presents the result with a one-cycle done handshake.
//
// state | meaning
// IDLE  | waiting for an M op; latches operands on start
// BUSY  | one shift-add / restoring-divide step per cycle, 32 steps
// DONE  | sign-corrected result on result_o, held while hold_i
module ex_muldiv_unit
  import rv32i_types::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            flush_i,
  input  logic            hold_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t state, state_nxt;
  logic   load;

  logic [CNT_W-1:0]  cnt;
  muldiv_op_t        op_q;
  logic              neg_prod_q, neg_quo_q, neg_rem_q;
  logic              div_zero_q, ovf_q;
  logic [XLEN:0]     a_mag, b_mag;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   quo;
  logic [XLEN:0]     rem;
  logic [XLEN-1:0]   result_q;
  logic [XLEN-1:0]   fix_result;

  muldiv_op_t    op_in;
  logic          sa_in, sb_in, div_zero_in, ovf_in, special_in;
  logic [XLEN:0] a_mag_in, b_mag_in;

  assign op_in = muldiv_op_t'(funct3_i);
  assign sa_in = rs1_data_i[XLEN-1] &
                 (op_in == OP_MULH || op_in == OP_MULHSU || op_in == OP_DIV || op_in == OP_REM);
  assign sb_in = rs2_data_i[XLEN-1] &
                 (op_in == OP_MULH || op_in == OP_DIV || op_in == OP_REM);
  assign a_mag_in = sa_in ? {1'b0, ~rs1_data_i + 1'b1} : {1'b0, rs1_data_i};
  assign b_mag_in = sb_in ? {1'b0, ~rs2_data_i + 1'b1} : {1'b0, rs2_data_i};

  assign div_zero_in = is_div_op(op_in) && (rs2_data_i == '0);
  assign ovf_in      = (op_in == OP_DIV || op_in == OP_REM) &&
                       (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data_i == '1);
  assign special_in  = div_zero_in | ovf_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    stall_o   = 1'b0;
    done_o    = 1'b0;
    case (state)
      IDLE: begin
        if (start_i && !flush_i) begin
          load      = 1'b1;
          stall_o   = 1'b1;
          state_nxt = special_in ? DONE : BUSY;
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        if (flush_i)                            state_nxt = IDLE;
        else if (cnt == CNT_W'(XLEN - 1))       state_nxt = DONE;
      end
      DONE: begin
        done_o = 1'b1;
        if (flush_i || !hold_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  logic [2*XLEN-1:0] addend;
  logic [XLEN:0]     shifted;
  logic [XLEN+1:0]   diff;

  assign addend  = b_mag[cnt[4:0]] ? ({{XLEN{1'b0}}, a_mag[XLEN-1:0]} << cnt) : '0;
  assign shifted = {rem[XLEN-1:0], quo[XLEN-1]};
  assign diff    = {1'b0, shifted} - {1'b0, b_mag};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      op_q       <= OP_MUL;
      neg_prod_q <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
      a_mag      <= '0;
      b_mag      <= '0;
      product    <= '0;
      quo        <= '0;
      rem        <= '0;
      result_q   <= '0;
    end else begin
      if (load) begin
        cnt        <= '0;
        op_q       <= op_in;
        neg_prod_q <= sa_in ^ sb_in;
        neg_quo_q  <= sa_in ^ sb_in;
        neg_rem_q  <= sa_in;
        div_zero_q <= div_zero_in;
        ovf_q      <= ovf_in;
        a_mag      <= a_mag_in;
        b_mag      <= b_mag_in;
        product    <= '0;
        quo        <= a_mag_in[XLEN-1:0];
        rem        <= div_zero_in ? a_mag_in : '0;
      end else if (state == BUSY) begin
        cnt <= cnt + 1'b1;
        if (is_div_op(op_q)) begin
          // Restoring step: keep the trial subtraction only if it did not borrow.
          if (!diff[XLEN+1]) begin
            rem <= diff[XLEN:0];
            quo <= {quo[XLEN-2:0], 1'b1};
          end else begin
            rem <= shifted;
            quo <= {quo[XLEN-2:0], 1'b0};
          end
        end else begin
          product <= product + addend;
        end
      end
      if (state == DONE) result_q <= fix_result;
    end
  end

  muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .op        (op_q),
    .neg_prod  (neg_prod_q),
    .neg_quo   (neg_quo_q),
    .neg_rem   (neg_rem_q),
    .div_zero  (div_zero_q),
    .overflow  (ovf_q),
    .product   (product),
    .quotient  (quo),
    .remainder (rem[XLEN-1:0]),
    .result    (fix_result)
  );

  assign result_o = done_o ? fix_result : result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: latency, results, special cases, flush,
// reset and hold behaviour against hand-computed values.
module tb_ex_muldiv_unit;
  import rv32i_types::*;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        flush_i;
  logic        hold_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] result_o;

  int n_checks = 0;
  int n_errors = 0;

  ex_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .funct3_i   (funct3_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .flush_i    (flush_i),
    .hold_i     (hold_i),
    .stall_o    (stall_o),
    .done_o     (done_o),
    .result_o   (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for done_o; n returns the cycle index relative to start.
  task automatic wait_done(output int n, output logic stall_ok);
    n = 1;
    stall_ok = 1'b1;
    while (!done_o && n < 40) begin
      if (!stall_o) stall_ok = 1'b0;
      tick();
      n++;
    end
  endtask

  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start_i = 1'b1; funct3_i = op; rs1_data_i = a; rs2_data_i = b;
    #1;
  endtask

  // After the start edge, scramble operands to prove they are only sampled in IDLE.
  task automatic scramble(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start_i = 1'b0; funct3_i = ~op; rs1_data_i = ~a; rs2_data_i = ~b;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int   n;
    logic stall_ok;
    launch(op, a, b);
    check_val({tag, " stall_c0"}, 32'(stall_o), 32'd1);
    tick();
    scramble(op, a, b);
    wait_done(n, stall_ok);
    check_val({tag, " latency"}, 32'(n), 32'(lat));
    check_val({tag, " result"}, result_o, exp);
    check_val({tag, " stall_busy"}, 32'(stall_ok), 32'd1);
    check_val({tag, " stall_done"}, 32'(stall_o), 32'd0);
    tick();
    check_val({tag, " done_drop"}, 32'(done_o), 32'd0);
  endtask

  initial begin
    int   n;
    logic stall_ok;
    logic seen;

    rst = 1'b0; start_i = 1'b0; funct3_i = '0; rs1_data_i = '0; rs2_data_i = '0;
    flush_i = 1'b0; hold_i = 1'b0;
    tick(); tick();
    check_val("reset stall", 32'(stall_o), 32'd0);
    check_val("reset done", 32'(done_o), 32'd0);
    check_val("reset result", result_o, 32'd0);
    rst = 1'b1;
    tick();

    run_op("mul_7x-3",    OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run_op("mulh_min",    OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    run_op("mulhu_max",   OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("mulhsu",      OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33);
    run_op("div_-7/2",    OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
    run_op("rem_-7/2",    OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
    run_op("divu_max/2",  OP_DIVU,   32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF, 33);
    run_op("remu_100/7",  OP_REMU,   32'd100,       32'd7,         32'd2,         33);
    run_op("div_5/0",     OP_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    run_op("remu_5/0",    OP_REMU,   32'd5,         32'd0,         32'd5,         1);
    run_op("div_ovf",     OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",     OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
    run_op("rem_-7/0",    OP_REM,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1);

    // Flush a DIVU in BUSY at cycle 10
    launch(OP_DIVU, 32'hFFFF_FFFF, 32'd3);
    tick();
    scramble(OP_DIVU, 32'hFFFF_FFFF, 32'd3);
    repeat (9) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check_val("flush stall_c11", 32'(stall_o), 32'd0);
    check_val("flush done_c11", 32'(done_o), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      if (done_o) seen = 1'b1;
      tick();
    end
    check_val("flush no_done", 32'(seen), 32'd0);
    run_op("mul_3x4", OP_MUL, 32'd3, 32'd4, 32'd12, 33);

    // Flush in IDLE blocks the start
    flush_i = 1'b1;
    launch(OP_MUL, 32'd2, 32'd2);
    check_val("idle_flush stall", 32'(stall_o), 32'd0);
    tick();
    start_i = 1'b0; flush_i = 1'b0;
    check_val("idle_flush busy", 32'(stall_o), 32'd0);

    // Reset mid-BUSY
    launch(OP_MUL, 32'd5, 32'd6);
    tick();
    scramble(OP_MUL, 32'd5, 32'd6);
    repeat (5) tick();
    #2;
    rst = 1'b0;
    #1;
    check_val("rst stall", 32'(stall_o), 32'd0);
    check_val("rst done", 32'(done_o), 32'd0);
    check_val("rst result", result_o, 32'd0);
    #1;
    rst = 1'b1;
    tick();
    check_val("rst idle_done", 32'(done_o), 32'd0);
    run_op("remu_after_rst", OP_REMU, 32'd100, 32'd7, 32'd2, 33);

    // hold_i for 3 cycles on entering DONE
    launch(OP_DIV, 32'd100, 32'd7);
    tick();
    scramble(OP_DIV, 32'd100, 32'd7);
    wait_done(n, stall_ok);
    check_val("hold latency", 32'(n), 32'd33);
    hold_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_val("hold done", 32'(done_o), 32'd1);
      check_val("hold result", result_o, 32'd14);
      check_val("hold stall", 32'(stall_o), 32'd0);
      tick();
      if (i == 2) hold_i = 1'b0;
    end
    check_val("hold released", 32'(done_o), 32'd0);
    check_val("hold result_kept", result_o, 32'd14);

    // flush has priority over hold in DONE
    launch(OP_DIVU, 32'd100, 32'd10);
    tick();
    scramble(OP_DIVU, 32'd100, 32'd10);
    wait_done(n, stall_ok);
    check_val("flush_hold result", result_o, 32'd10);
    hold_i = 1'b1; flush_i = 1'b1;
    tick();
    hold_i = 1'b0; flush_i = 1'b0;
    check_val("flush_hold done", 32'(done_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide engine in the EX stage.
- Directly downstream of the EX forwarding unit: consumes the already-forwarded rs1/rs2 operand values and produces a 32-bit result for the EX/MEM register.
- Holds the pipeline through stall_o while computing. Result is delivered with a one-cycle done_o handshake.

Parameters:
- XLEN, 32, operand/result width (only 32 supported)
- CNT_W, 6, iteration counter width (must be able to hold XLEN)

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- start_i  in  1  ID/EX holds a valid M-extension op
- funct3_i  in  3  muldiv_op_t (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
- rs1_data_i  in  32  forwarded operand A
- rs2_data_i  in  32  forwarded operand B
- flush_i  in  1  branch/jump kill of the EX instruction
- hold_i  in  1  downstream (MEM) stall; EX/MEM cannot accept
- stall_o  out  1  freeze PC/IF/ID/ID-EX
- done_o  out  1  result_o valid this cycle
- result_o  out  32  selected result

Behaviour:
- Reset (rst=0, async): state=IDLE, counter=0, all datapath regs=0, done_o=0, result_o=0, stall_o=0.
- States:
  - IDLE
  - BUSY
  - DONE
- IDLE:
  - If start_i && !flush_i: latch op, sign flags and operand magnitudes as 33-bit values.
  - MULHSU: rs1 signed, rs2 unsigned.
  - If the op is a special case, go to DONE. Otherwise go to BUSY with counter=0.
- BUSY:
  - One iteration per cycle, 32 iterations (counter 0..31).
  - Multiply: shift-add on magnitudes into a 64-bit product.
  - Divide: restoring, one quotient bit per cycle.
  - After the iteration at counter==31, go to DONE.
- DONE:
  - Apply sign correction.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Product is negated if the signs differ.
  - Select the result:
    - MUL: low 32 bits
    - MULH/MULHSU/MULHU: high 32 bits
    - DIV/DIVU: quotient
    - REM/REMU: remainder
  - Stay in DONE while hold_i=1, with result_o stable. Otherwise go to IDLE next cycle.
- Special cases (1-cycle path IDLE→DONE, no BUSY):
  - Divide by zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → rs1.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV → 0x80000000; REM → 0.
- Outputs:
  - stall_o = (state==BUSY) | (state==IDLE & start_i & !flush_i). Combinational, so the first cycle is stalled.
  - done_o = (state==DONE). result_o is valid only while done_o=1 and holds its last value otherwise.
- Latency (start seen in IDLE at cycle 0):
  - Normal ops: done_o at cycle 33; stall_o high cycles 0..32.
  - Special cases: done_o at cycle 1; stall_o high at cycle 0 only.
- Flush:
  - flush_i in BUSY or DONE → IDLE next edge; done_o is not asserted afterwards.
  - flush_i in IDLE blocks the start.
  - flush_i has priority over hold_i.
- Back-to-back M ops: DONE→IDLE, then the next start is accepted in IDLE (one bubble cycle).
- Reset mid-operation: immediate IDLE, partial state discarded.
- funct3_i and operands are sampled only in IDLE; later changes are ignored.

Decomposition:
- rv32i_types package holds muldiv_op_t (3-bit enum mirroring funct3), next to data_forward_t.
- The FSM state enum is local to this module.
- One natural sub-module: muldiv_sign_fix, a combinational final negate/select stage used in DONE. Everything else is a single FSM+datapath.

Test Plan:
- MUL 7 × 0xFFFFFFFD (-3), start at cycle 0:
  - result_o = 0xFFFFFFEB at cycle 33 with done_o=1.
  - stall_o=1 for cycles 0..32 and 0 at cycle 33.
- High-word products:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- Division:
  - DIV 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD.
  - REM same operands → 0xFFFFFFFF.
  - DIVU 0xFFFFFFFF / 2 → 0x7FFFFFFF.
  - REMU 100 / 7 → 2.
- Special cases:
  - DIV 5/0 → 0xFFFFFFFF at cycle 1.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM same operands → 0.
  - All complete with done_o at cycle 1.
- Flush and reset:
  - flush_i pulsed at cycle 10 of a DIVU: state IDLE at cycle 11, stall_o=0, done_o never asserted.
  - A following MUL 3×4 → 12 at cycle 33 after its start.
  - rst pulsed low mid-BUSY: all outputs 0 immediately.
- hold_i=1 for 3 cycles on entering DONE (DIV 100/7):
  - done_o=1 and result_o=14 stable for 4 cycles.
  - IDLE on the cycle after hold_i drops.
